// File: rtl/spike_count_decoder_if.sv
// Handshake/bus bundle between the final-layer spike buffer, the spike count
// decoder and the downstream action/control logic.
interface spike_count_decoder_if #(
    parameter int NUM_NEURONS   = 2,
    parameter int NUM_TIMESTEPS = 30
);
    localparam int COUNT_W = $clog2(NUM_TIMESTEPS + 1);
    localparam int IDX_W   = $clog2(NUM_NEURONS);

    logic                   start;
    logic [NUM_NEURONS-1:0] spikes_in;
    logic [4:0]             timestep_in;
    logic                   timestep_valid;
    logic                   layer_done;
    logic                   busy;
    logic                   result_valid;
    logic [IDX_W-1:0]       action;
    logic [COUNT_W-1:0]     max_count;
    logic                   seq_error;

    modport master (
        output start, spikes_in, timestep_in, timestep_valid, layer_done,
        input  busy, result_valid, action, max_count, seq_error
    );

    modport slave (
        input  start, spikes_in, timestep_in, timestep_valid, layer_done,
        output busy, result_valid, action, max_count, seq_error
    );
endinterface

// File: rtl/spike_count_decoder.sv
// Rate decoder: counts spikes per output neuron over one inference, then picks the
// neuron with the highest count. SPIKE_COUNT_DECODER_COUNTS_OUT_EN exposes the counters.
module spike_count_decoder #(
    parameter int NUM_NEURONS   = 2,
    parameter int NUM_TIMESTEPS = 30
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    spike_count_decoder_if.slave  bus
`ifdef SPIKE_COUNT_DECODER_COUNTS_OUT_EN
    ,
    output logic [NUM_NEURONS*$clog2(NUM_TIMESTEPS+1)-1:0] counts_out_o
`endif
);
    localparam int COUNT_W = $clog2(NUM_TIMESTEPS + 1);
    localparam int IDX_W   = $clog2(NUM_NEURONS);
    localparam logic [COUNT_W-1:0] TS_LAST  = COUNT_W'(NUM_TIMESTEPS);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_ARGMAX = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] counts_q [NUM_NEURONS];
    logic [COUNT_W-1:0] counts_d [NUM_NEURONS];
    logic [COUNT_W-1:0] exp_ts_q, exp_ts_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [COUNT_W-1:0] best_cnt_q, best_cnt_d;
    logic [IDX_W-1:0]   action_q, action_d;
    logic [COUNT_W-1:0] max_count_q, max_count_d;
    logic               result_valid_q, result_valid_d;
    logic               seq_error_q, seq_error_d;

    logic               accept_s;
    logic [COUNT_W-1:0] exp_after_s;
    logic               ts_err_s;
    logic               ovf_err_s;
    logic               len_err_s;
    logic               take_s;
    logic [IDX_W-1:0]   cand_idx_s;
    logic [COUNT_W-1:0] cand_cnt_s;

    // Once all timesteps are in, further valids are dropped so counters cannot overflow.
    assign accept_s    = bus.timestep_valid && (exp_ts_q < TS_LAST);
    assign exp_after_s = accept_s ? (exp_ts_q + COUNT_W'(1)) : exp_ts_q;
    assign ts_err_s    = accept_s && (bus.timestep_in != 5'(exp_ts_q));
    assign ovf_err_s   = bus.timestep_valid && !accept_s;
    assign len_err_s   = bus.layer_done && (exp_after_s != TS_LAST);

    // Index 0 always seeds the running best; strict compare keeps the lowest index on ties.
    assign take_s     = (counts_q[idx_q] > best_cnt_q) || (idx_q == {IDX_W{1'b0}});
    assign cand_idx_s = take_s ? idx_q : best_idx_q;
    assign cand_cnt_s = take_s ? counts_q[idx_q] : best_cnt_q;

    // Next-state logic: start overrides everything and (re)opens accumulation.
    always_comb begin
        state_d        = state_q;
        counts_d       = counts_q;
        exp_ts_d       = exp_ts_q;
        idx_d          = idx_q;
        best_idx_d     = best_idx_q;
        best_cnt_d     = best_cnt_q;
        action_d       = action_q;
        max_count_d    = max_count_q;
        result_valid_d = 1'b0;
        seq_error_d    = seq_error_q;
        if (bus.start) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                counts_d[n] = {COUNT_W{1'b0}};
            end
            exp_ts_d    = {COUNT_W{1'b0}};
            seq_error_d = 1'b0;
            state_d     = ST_ACCUM;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept_s) begin
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            counts_d[n] = counts_q[n] + COUNT_W'(bus.spikes_in[n]);
                        end
                    end else begin
                        counts_d = counts_q;
                    end
                    exp_ts_d    = exp_after_s;
                    seq_error_d = seq_error_q | ts_err_s | ovf_err_s | len_err_s;
                    if (bus.layer_done) begin
                        state_d    = ST_ARGMAX;
                        idx_d      = {IDX_W{1'b0}};
                        best_idx_d = {IDX_W{1'b0}};
                        best_cnt_d = {COUNT_W{1'b0}};
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_ARGMAX: begin
                    if (idx_q == IDX_LAST) begin
                        action_d       = cand_idx_s;
                        max_count_d    = cand_cnt_s;
                        result_valid_d = 1'b1;
                        state_d        = ST_HOLD;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        best_idx_d = cand_idx_s;
                        best_cnt_d = cand_cnt_s;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                counts_q[n] <= {COUNT_W{1'b0}};
            end
            exp_ts_q       <= {COUNT_W{1'b0}};
            idx_q          <= {IDX_W{1'b0}};
            best_idx_q     <= {IDX_W{1'b0}};
            best_cnt_q     <= {COUNT_W{1'b0}};
            action_q       <= {IDX_W{1'b0}};
            max_count_q    <= {COUNT_W{1'b0}};
            result_valid_q <= 1'b0;
            seq_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            counts_q       <= counts_d;
            exp_ts_q       <= exp_ts_d;
            idx_q          <= idx_d;
            best_idx_q     <= best_idx_d;
            best_cnt_q     <= best_cnt_d;
            action_q       <= action_d;
            max_count_q    <= max_count_d;
            result_valid_q <= result_valid_d;
            seq_error_q    <= seq_error_d;
        end
    end

    assign bus.busy         = (state_q == ST_ACCUM) || (state_q == ST_ARGMAX);
    assign bus.result_valid = result_valid_q;
    assign bus.action       = action_q;
    assign bus.max_count    = max_count_q;
    assign bus.seq_error    = seq_error_q;

`ifdef SPIKE_COUNT_DECODER_COUNTS_OUT_EN
    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_counts_out
        assign counts_out_o[g*COUNT_W +: COUNT_W] = counts_q[g];
    end
`endif
endmodule

// File: tb/tb_spike_count_decoder.sv
// Bench for spike_count_decoder: a 2-neuron and an 8-neuron instance driven by
// directed table vectors, hand sequences and random patterns checked against a model.
module tb_spike_count_decoder;
    localparam int NT = 30;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    spike_count_decoder_if #(.NUM_NEURONS(2), .NUM_TIMESTEPS(NT)) if2 ();
    spike_count_decoder_if #(.NUM_NEURONS(8), .NUM_TIMESTEPS(NT)) if8 ();

`ifdef SPIKE_COUNT_DECODER_COUNTS_OUT_EN
    logic [2*CW-1:0] co2;
    logic [8*CW-1:0] co8;
`endif

    spike_count_decoder #(.NUM_NEURONS(2), .NUM_TIMESTEPS(NT)) dut2 (
        .clk_i(clk), .reset_i(reset_i), .bus(if2)
`ifdef SPIKE_COUNT_DECODER_COUNTS_OUT_EN
        , .counts_out_o(co2)
`endif
    );

    spike_count_decoder #(.NUM_NEURONS(8), .NUM_TIMESTEPS(NT)) dut8 (
        .clk_i(clk), .reset_i(reset_i), .bus(if8)
`ifdef SPIKE_COUNT_DECODER_COUNTS_OUT_EN
        , .counts_out_o(co8)
`endif
    );

    int checks = 0;
    int failures = 0;
    int rvc2 = 0;
    int rvc8 = 0;
    logic [7:0] pat [32];
    int mcnt [8];

    typedef struct {
        int n0; int n1; int nv; bit skip; bit merge; int ea; int em; bit ee;
    } vec_t;
    vec_t tbl [7];

    always @(posedge clk) begin
        if (if2.result_valid) rvc2 <= rvc2 + 1;
        if (if8.result_valid) rvc8 <= rvc8 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input bit st, input bit v, input logic [7:0] sp,
                         input int ts, input bit ld);
        if (sel == 2) begin
            if2.start = st; if2.timestep_valid = v; if2.spikes_in = sp[1:0];
            if2.timestep_in = 5'(ts); if2.layer_done = ld;
        end else begin
            if8.start = st; if8.timestep_valid = v; if8.spikes_in = sp;
            if8.timestep_in = 5'(ts); if8.layer_done = ld;
        end
    endtask

    task automatic peek(input int sel, output bit rv, output int act, output int mx,
                        output bit er, output bit bz);
        if (sel == 2) begin
            rv = if2.result_valid; act = int'(if2.action); mx = int'(if2.max_count);
            er = if2.seq_error; bz = if2.busy;
        end else begin
            rv = if8.result_valid; act = int'(if8.action); mx = int'(if8.max_count);
            er = if8.seq_error; bz = if8.busy;
        end
    endtask

    // Reference: only the first NT valids count; winner is the lowest index with the top count.
    function automatic void model(input int nn, input int nv, input bit skip,
                                  output int act, output int mx, output bit er);
        int lim;
        lim = (nv < NT) ? nv : NT;
        for (int n = 0; n < 8; n++) mcnt[n] = 0;
        for (int t = 0; t < lim; t++)
            for (int n = 0; n < nn; n++) mcnt[n] += int'(pat[t][n]);
        act = 0;
        for (int n = 1; n < nn; n++) if (mcnt[n] > mcnt[act]) act = n;
        mx = mcnt[act];
        er = skip || (nv != NT);
    endfunction

    task automatic run_chk(input int sel, input int nv, input bit skip, input bit merge,
                           input int ea, input int em, input bit ee, input string nm);
        int lat, act, mx, dea, dem;
        bit rv, er, bz, dee;
        model(sel, nv, skip, dea, dem, dee);
        drive(sel, 1'b1, 1'b1, 8'hFF, 0, 1'b0);
        tick();
        for (int t = 0; t < nv; t++) begin
            drive(sel, 1'b0, 1'b1, pat[t], (skip && t >= 2) ? t + 1 : t, merge && (t == nv - 1));
            tick();
        end
        if (!merge) begin
            drive(sel, 1'b0, 1'b0, 8'h00, 0, 1'b1);
            tick();
        end
        drive(sel, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        lat = 1;
        peek(sel, rv, act, mx, er, bz);
        while (!rv && lat < 40) begin
            tick();
            lat++;
            peek(sel, rv, act, mx, er, bz);
        end
        chk({nm, "_latency"}, lat, sel + 1);
        chk({nm, "_action"}, act, ea);
        chk({nm, "_max_count"}, mx, em);
        chk({nm, "_seq_error"}, int'(er), int'(ee));
`ifdef SPIKE_COUNT_DECODER_COUNTS_OUT_EN
        for (int n = 0; n < sel; n++)
            chk({nm, "_counts_out"}, (sel == 2) ? int'(co2[n*CW +: CW]) : int'(co8[n*CW +: CW]),
                mcnt[n]);
`endif
        tick();
        peek(sel, rv, act, mx, er, bz);
        chk({nm, "_pulse_width"}, int'(rv), 0);
        chk({nm, "_busy_hold"}, int'(bz), 0);
    endtask

    initial begin
        int ea, em, nv, base, sel;
        int cnt8 [8];
        bit ee, rv, er, bz, mg;
        int act, mx;

        tbl[0] = '{7, 18, 30, 1'b0, 1'b0, 1, 18, 1'b0};
        tbl[1] = '{30, 30, 30, 1'b0, 1'b0, 0, 30, 1'b0};
        tbl[2] = '{0, 0, 30, 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[3] = '{10, 11, 30, 1'b0, 1'b0, 1, 11, 1'b0};
        tbl[4] = '{30, 29, 30, 1'b0, 1'b1, 0, 30, 1'b0};
        tbl[5] = '{31, 0, 31, 1'b0, 1'b0, 0, 30, 1'b1};
        tbl[6] = '{2, 4, 29, 1'b1, 1'b0, 1, 4, 1'b1};

        reset_i = 1'b1;
        drive(2, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        drive(8, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        tick();
        tick();
        reset_i = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 0) ? 2 : 8;
            peek(sel, rv, act, mx, er, bz);
            chk("reset_result_valid", int'(rv), 0);
            chk("reset_action", act, 0);
            chk("reset_max_count", mx, 0);
            chk("reset_seq_error", int'(er), 0);
            chk("reset_busy", int'(bz), 0);
        end

        for (int i = 0; i < 7; i++) begin
            for (int t = 0; t < 32; t++)
                pat[t] = {6'b0, 1'(t < tbl[i].n1), 1'(t < tbl[i].n0)};
            run_chk(2, tbl[i].nv, tbl[i].skip, tbl[i].merge, tbl[i].ea, tbl[i].em, tbl[i].ee,
                    $sformatf("vec%0d", i));
        end

        // Start after an errored run clears the flag but keeps the last result.
        drive(2, 1'b1, 1'b0, 8'h00, 0, 1'b0);
        tick();
        drive(2, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        peek(2, rv, act, mx, er, bz);
        chk("start_clears_seq_error", int'(er), 0);
        chk("start_busy", int'(bz), 1);
        chk("start_keeps_action", act, 1);
        chk("start_keeps_max_count", mx, 4);

        // Reset while the argmax scan is running.
        for (int t = 0; t < NT; t++) begin
            drive(2, 1'b0, 1'b1, 8'h02, t, 1'b0);
            tick();
        end
        drive(2, 1'b0, 1'b0, 8'h00, 0, 1'b1);
        tick();
        drive(2, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        base = rvc2;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        peek(2, rv, act, mx, er, bz);
        chk("argmax_reset_action", act, 0);
        chk("argmax_reset_max_count", mx, 0);
        chk("argmax_reset_busy", int'(bz), 0);
        for (int k = 0; k < 5; k++) tick();
        chk("argmax_reset_no_result", rvc2 - base, 0);

        // Abort after 10 timesteps, then a full run with neuron0 spiking 5 times.
        base = rvc2;
        drive(2, 1'b1, 1'b0, 8'h00, 0, 1'b0);
        tick();
        for (int t = 0; t < 10; t++) begin
            drive(2, 1'b0, 1'b1, 8'h03, t, 1'b0);
            tick();
        end
        for (int t = 0; t < 32; t++) pat[t] = {7'b0, 1'(t < 5)};
        run_chk(2, NT, 1'b0, 1'b0, 0, 5, 1'b0, "abort");
        chk("abort_pulse_count", rvc2 - base, 1);

        cnt8 = '{3, 9, 9, 1, 0, 12, 12, 4};
        for (int t = 0; t < 32; t++)
            for (int n = 0; n < 8; n++) pat[t][n] = (t < cnt8[n]);
        run_chk(8, NT, 1'b0, 1'b0, 5, 12, 1'b0, "n8_directed");

        for (int i = 0; i < 10; i++) begin
            sel = (i % 2 == 1) ? 8 : 2;
            nv = (i < 6) ? NT : int'($urandom_range(28, 31));
            mg = 1'($urandom_range(0, 1));
            for (int t = 0; t < 32; t++) pat[t] = 8'($urandom);
            model(sel, nv, 1'b0, ea, em, ee);
            run_chk(sel, nv, 1'b0, mg, ea, em, ee, $sformatf("rand%0d_n%0d", i, sel));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spike_count_decoder.md
Name: spike_count_decoder

Overview:
- Output-side decoder that sits directly downstream of the spike buffer of the final SNN layer.
- Consumes one synchronized spike vector per timestep, accumulates a per-neuron spike count over all timesteps, then selects the action as the neuron with the highest count (rate decoding).
- Feeds the CartPole action/control interface with `action`, `max_count` and a one-cycle `result_valid` pulse.

Parameters:
- NUM_NEURONS, 2, output-layer neurons (actions); legal range 2..64.
- NUM_TIMESTEPS, 30, timesteps per inference; legal range 1..31.
- COUNT_W, $clog2(NUM_TIMESTEPS+1), width of each spike counter (derived; not overridden).
- IDX_W, $clog2(NUM_NEURONS), width of the action index (derived).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  clears counts and begins a new inference; pulsed together with the buffer's start.
- spikes_in  input  NUM_NEURONS  spike vector for the current timestep (from buffer spikes_out).
- timestep_in  input  5  timestep index of spikes_in.
- timestep_valid  input  1  spikes_in/timestep_in valid this cycle.
- layer_done  input  1  buffer has output all timesteps (single-cycle pulse).
- busy  output  1  high in ACCUM or ARGMAX.
- result_valid  output  1  one-cycle pulse: action/max_count are fresh.
- action  output  IDX_W  index of the winning neuron.
- max_count  output  COUNT_W  spike count of the winning neuron.
- seq_error  output  1  sticky protocol-error flag; cleared by start.

Behaviour:
- Reset:
  - state=IDLE; all counts=0.
  - busy=0, result_valid=0, action=0, max_count=0, seq_error=0.
  - Expected-timestep counter exp_ts=0.
- States: IDLE, ACCUM, ARGMAX, HOLD.
- IDLE or HOLD, start=1:
  - counts←0, exp_ts←0, seq_error←0.
  - Go to ACCUM.
  - action/max_count keep their old values until the next result.
- ACCUM, timestep_valid=1 and exp_ts<NUM_TIMESTEPS:
  - counts[n] += spikes_in[n] for all n, in the same cycle; exp_ts++.
  - If timestep_in≠exp_ts: seq_error←1, but still accumulate.
- ACCUM, timestep_valid=1 and exp_ts==NUM_TIMESTEPS:
  - Ignore the data and set seq_error.
  - Counters therefore never exceed NUM_TIMESTEPS and need no saturation logic.
- ACCUM, layer_done=1:
  - Go to ARGMAX with idx=0, best_idx=0, best_cnt=0.
  - If exp_ts≠NUM_TIMESTEPS after including any same-cycle valid: seq_error←1.
  - A timestep_valid in the same cycle as layer_done is accumulated first.
- ARGMAX:
  - Scans one neuron per cycle for NUM_NEURONS cycles.
  - If counts[idx] > best_cnt (strict) or idx==0: best ← (idx, counts[idx]).
  - Ties resolve to the lowest index; all-zero counts give action=0, max_count=0.
  - After idx==NUM_NEURONS-1: register action/max_count, pulse result_valid, go to HOLD.
- Latency: with layer_done sampled in cycle L, result_valid is high in cycle L+NUM_NEURONS+1 for exactly one cycle.
- timestep_valid or layer_done in IDLE, ARGMAX or HOLD: ignored; no error flagged.
- start in ACCUM or ARGMAX: abort and restart.
  - Clear counts and exp_ts; go to ACCUM.
  - No result_valid is issued for the aborted inference; action/max_count are unchanged.
- start takes priority over timestep_valid/layer_done in the same cycle; spikes presented that cycle are discarded.
- reset mid-operation: returns everything to reset values on the next edge; no result_valid is produced.
- busy is combinational from state: 1 in ACCUM/ARGMAX, 0 otherwise.

Optional Feature:
- Macro: SPIKE_COUNT_DECODER_COUNTS_OUT_EN.
- Defined:
  - Adds output port `counts_out [NUM_NEURONS*COUNT_W-1:0]`; neuron n occupies bits [n*COUNT_W +: COUNT_W].
  - It exposes the live counters: valid and stable from result_valid until the next start.
  - Used for Q-value/debug readout.
- Undefined: the port is absent and the counters stay internal; all other behaviour is identical.

Test Plan:
- NUM_NEURONS=2, NUM_TIMESTEPS=30: start, then 30 valids ts 0..29 with neuron1 spiking on 18 and neuron0 on 7, then layer_done → result_valid exactly 3 cycles after layer_done with action=1, max_count=18, seq_error=0.
- Tie: both neurons spike on all 30 timesteps → action=0, max_count=30; no spikes at all → action=0, max_count=0.
- Sequence error: timestep_in sequence 0,1,3,… (29 valids), then layer_done → seq_error=1 and a result is still produced; the next start clears seq_error to 0.
- Abort: start, 10 valids, start again, then a full 30-step run with neuron0 spiking 5 times → exactly one result_valid pulse, action=0, max_count=5.
- Boundary: valid with ts 29 in the same cycle as layer_done is counted; a 31st valid is ignored and sets seq_error; reset asserted in ARGMAX → no result_valid, outputs=0.
- NUM_NEURONS=8: counts {3,9,9,1,0,12,12,4} → action=5, max_count=12, result_valid 9 cycles after layer_done; with SPIKE_COUNT_DECODER_COUNTS_OUT_EN defined, counts_out matches per-neuron counts.
